// File: rtl/vga_timing.sv
// Raster timing generator: free-running pixel/line counters, sync and blank
// decode delayed to align with registered pixel data, and undelayed strobes.
module vga_timing #(
  parameter int unsigned H_VISIBLE  = 800,
  parameter int unsigned H_FRONT    = 56,
  parameter int unsigned H_SYNC     = 120,
  parameter int unsigned H_BACK     = 64,
  parameter int unsigned V_VISIBLE  = 600,
  parameter int unsigned V_FRONT    = 37,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BACK     = 23,
  parameter logic        SYNC_POL   = 1'b1,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic        vclk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hs_raw, vs_raw, bl_raw;

  // Using >= rather than == means an upset counter still wraps instead of
  // running past the end of the raster.
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q >= H_LAST) begin
      hcount_d = 11'd0;
      if (vcount_q >= V_LAST) begin
        vcount_d = 10'd0;
      end else begin
        vcount_d = vcount_q + 10'd1;
      end
    end else begin
      hcount_d = hcount_q + 11'd1;
    end
  end

  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      hcount_q <= 11'd0;
      vcount_q <= 10'd0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  always_comb begin
    if ((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST)) begin
      hs_raw = SYNC_POL;
    end else begin
      hs_raw = ~SYNC_POL;
    end
    if ((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST)) begin
      vs_raw = SYNC_POL;
    end else begin
      vs_raw = ~SYNC_POL;
    end
    if ((hcount_q >= H_VIS) || (vcount_q >= V_VIS)) begin
      bl_raw = 1'b1;
    end else begin
      bl_raw = 1'b0;
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodelay
      assign hsync = hs_raw;
      assign vsync = vs_raw;
      assign blank = bl_raw;
    end else begin : g_delay
      logic [PIPE_DELAY-1:0] hs_q, hs_d;
      logic [PIPE_DELAY-1:0] vs_q, vs_d;
      logic [PIPE_DELAY-1:0] bl_q, bl_d;

      // Stage 0 takes the fresh decode; the top stage drives the output.
      always_comb begin
        hs_d    = hs_q << 1;
        vs_d    = vs_q << 1;
        bl_d    = bl_q << 1;
        hs_d[0] = hs_raw;
        vs_d[0] = vs_raw;
        bl_d[0] = bl_raw;
      end

      always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
          hs_q <= {PIPE_DELAY{~SYNC_POL}};
          vs_q <= {PIPE_DELAY{~SYNC_POL}};
          bl_q <= {PIPE_DELAY{1'b1}};
        end else begin
          hs_q <= hs_d;
          vs_q <= vs_d;
          bl_q <= bl_d;
        end
      end

      assign hsync = hs_q[PIPE_DELAY-1];
      assign vsync = vs_q[PIPE_DELAY-1];
      assign blank = bl_q[PIPE_DELAY-1];
    end
  endgenerate

  // Strobes are gated by rst so they stay quiet while the counters sit at 0.
  always_comb begin
    if (!rst && (hcount_q == 11'd0)) begin
      line_start = 1'b1;
    end else begin
      line_start = 1'b0;
    end
    if (!rst && (hcount_q == 11'd0) && (vcount_q == 10'd0)) begin
      frame_start = 1'b1;
    end else begin
      frame_start = 1'b0;
    end
  end

  assign hcount = hcount_q;
  assign vcount = vcount_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default, pipe-depth variants, and a shrunken
// raster (15 x 8) used for whole-frame, polarity and mid-frame reset checks.
module tb_vga_timing;

  logic vclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 vclk = ~vclk;

  logic [10:0] d1_h, d0_h, d4_h, sm_h, ng_h;
  logic [9:0]  d1_v, d0_v, d4_v, sm_v, ng_v;
  logic d1_hs, d1_vs, d1_bl, d1_ls, d1_fs;
  logic d0_hs, d0_vs, d0_bl, d0_ls, d0_fs;
  logic d4_hs, d4_vs, d4_bl, d4_ls, d4_fs;
  logic sm_hs, sm_vs, sm_bl, sm_ls, sm_fs;
  logic ng_hs, ng_vs, ng_bl, ng_ls, ng_fs;

  vga_timing u_d1 (
    .vclk(vclk), .rst(rst), .hcount(d1_h), .vcount(d1_v), .hsync(d1_hs),
    .vsync(d1_vs), .blank(d1_bl), .line_start(d1_ls), .frame_start(d1_fs));

  vga_timing #(.PIPE_DELAY(0)) u_d0 (
    .vclk(vclk), .rst(rst), .hcount(d0_h), .vcount(d0_v), .hsync(d0_hs),
    .vsync(d0_vs), .blank(d0_bl), .line_start(d0_ls), .frame_start(d0_fs));

  vga_timing #(.PIPE_DELAY(4)) u_d4 (
    .vclk(vclk), .rst(rst), .hcount(d4_h), .vcount(d4_v), .hsync(d4_hs),
    .vsync(d4_vs), .blank(d4_bl), .line_start(d4_ls), .frame_start(d4_fs));

  vga_timing #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
               .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_sm (
    .vclk(vclk), .rst(rst), .hcount(sm_h), .vcount(sm_v), .hsync(sm_hs),
    .vsync(sm_vs), .blank(sm_bl), .line_start(sm_ls), .frame_start(sm_fs));

  vga_timing #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
               .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
               .SYNC_POL(1'b0)) u_ng (
    .vclk(vclk), .rst(rst), .hcount(ng_h), .vcount(ng_v), .hsync(ng_hs),
    .vsync(ng_vs), .blank(ng_bl), .line_start(ng_ls), .frame_start(ng_fs));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sm(input logic [10:0] h, input logic [9:0] v, input string tag);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      if (sm_h == h && sm_v == v) found = 1'b1;
      else @(negedge vclk);
    end
    chk({"wait_", tag}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    int hs_cnt, hs_first, r1, r0, r4;
    logic p1, p0, p4;
    int ls_c, fs_c, hs_c, vs_c, bl_c, nhs_c, nvs_c, vf_h, vf_v;
    int cyc, hs_at, vs_at;

    // Reset state: counters 0, syncs idle, blank high, strobes quiet.
    repeat (5) @(negedge vclk);
    chk("rst_d1", {d1_h, d1_v, d1_hs, d1_vs, d1_bl, d1_ls, d1_fs}, 32'd4);
    chk("rst_d4", {d4_h, d4_v, d4_hs, d4_vs, d4_bl, d4_ls, d4_fs}, 32'd4);
    chk("rst_d0", {d0_h, d0_v, d0_ls, d0_fs}, 32'd0);
    chk("rst_sm", {sm_h, sm_v, sm_hs, sm_vs, sm_bl, sm_ls, sm_fs}, 32'd4);
    chk("rst_ng", {ng_h, ng_v, ng_hs, ng_vs, ng_bl, ng_ls, ng_fs}, 32'd28);

    // Release: cycle 0 shows 0,0 with both strobes.
    rst = 1'b0;
    #1;
    chk("rel_counts", {d1_h, d1_v}, 32'd0);
    chk("rel_strobes", {d1_ls, d1_fs}, 32'd3);
    chk("rel_delayed", {d1_hs, d1_vs, d1_bl}, 32'd1);
    @(negedge vclk);
    chk("first_edge_h", {21'd0, d1_h}, 32'd1);
    chk("first_edge_strobes", {d1_ls, d1_fs}, 32'd0);

    // One full default line, measuring sync width and blank edges.
    hs_cnt = 0; hs_first = -1; r1 = -1; r0 = -1; r4 = -1;
    p1 = 1'b1; p0 = 1'b1; p4 = 1'b1;
    for (int i = 1; i <= 1040; i++) begin
      if (d1_hs === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d1_h);
      end
      if (d1_bl === 1'b1 && p1 === 1'b0 && r1 < 0) r1 = int'(d1_h);
      if (d0_bl === 1'b1 && p0 === 1'b0 && r0 < 0) r0 = int'(d0_h);
      if (d4_bl === 1'b1 && p4 === 1'b0 && r4 < 0) r4 = int'(d4_h);
      p1 = d1_bl; p0 = d0_bl; p4 = d4_bl;
      if (i == 3)    chk("d4_reset_hold", {d4_hs, d4_vs, d4_bl}, 32'd1);
      if (i == 4)    chk("d4_first_decode", {31'd0, d4_bl}, 32'd0);
      if (i == 856)  chk("d0_d4_hsync_at_856", {d0_hs, d4_hs}, 32'd2);
      if (i == 860)  chk("d4_hsync_at_860", {31'd0, d4_hs}, 32'd1);
      if (i == 1039) chk("line_end", {d1_h, d1_v}, {11'd1039, 10'd0});
      if (i < 1040) @(negedge vclk);
    end
    chk("h_wrap", {d1_h, d1_v, d1_ls, d1_fs}, {11'd0, 10'd1, 1'b1, 1'b0});
    chk("hs_width", hs_cnt, 32'd120);
    chk("hs_first", hs_first, 32'd857);
    chk("blank_rise_d1", r1, 32'd801);
    chk("blank_rise_d0", r0, 32'd800);
    chk("blank_rise_d4", r4, 32'd804);
    chk("line0_vsync_idle", {d0_vs, d1_vs, d4_vs}, 32'd0);

    // Whole frame on the small raster: 15 x 8 = 120 cycles.
    wait_sm(11'd0, 10'd0, "frame0");
    ls_c = 0; fs_c = 0; hs_c = 0; vs_c = 0; bl_c = 0; nhs_c = 0; nvs_c = 0;
    vf_h = -1; vf_v = -1;
    for (int n = 0; n < 120; n++) begin
      if (sm_ls === 1'b1) ls_c++;
      if (sm_fs === 1'b1) fs_c++;
      if (sm_hs === 1'b1) hs_c++;
      if (sm_vs === 1'b1) vs_c++;
      if (sm_bl === 1'b1) bl_c++;
      if (ng_hs === 1'b0) nhs_c++;
      if (ng_vs === 1'b0) nvs_c++;
      if (sm_vs === 1'b1 && vf_h < 0) begin
        vf_h = int'(sm_h);
        vf_v = int'(sm_v);
      end
      if (n == 119) chk("frame_last", {sm_h, sm_v}, {11'd14, 10'd7});
      @(negedge vclk);
    end
    chk("frame_wrap", {sm_h, sm_v, sm_fs}, {11'd0, 10'd0, 1'b1});
    chk("frame_line_starts", ls_c, 32'd8);
    chk("frame_frame_starts", fs_c, 32'd1);
    chk("frame_hs_cycles", hs_c, 32'd24);
    chk("frame_vs_cycles", vs_c, 32'd30);
    chk("frame_blank_cycles", bl_c, 32'd88);
    chk("neg_hs_low_cycles", nhs_c, 32'd24);
    chk("neg_vs_low_cycles", nvs_c, 32'd30);
    chk("vsync_first_h", vf_h, 32'd1);
    chk("vsync_first_v", vf_v, 32'd5);

    // Mid-frame reset while both syncs are active.
    wait_sm(11'd11, 10'd6, "mid");
    chk("mid_syncs_active", {sm_hs, sm_vs, ng_hs, ng_vs}, 32'd12);
    rst = 1'b1;
    #1;
    chk("mid_rst_sm", {sm_h, sm_v, sm_hs, sm_vs, sm_bl, sm_ls, sm_fs}, 32'd4);
    chk("mid_rst_ng", {ng_hs, ng_vs, ng_bl}, 32'd7);
    chk("mid_rst_d1", {d1_h, d1_v, d1_hs, d1_vs, d1_bl}, 32'd1);
    repeat (2) @(negedge vclk);
    rst = 1'b0;
    #1;
    chk("restart", {sm_h, sm_v, sm_ls, sm_fs}, 32'd3);
    cyc = 0; hs_at = -1; vs_at = -1;
    for (int n = 0; n < 200 && vs_at < 0; n++) begin
      @(negedge vclk);
      cyc++;
      if (sm_hs === 1'b1 && hs_at < 0) hs_at = cyc;
      if (sm_vs === 1'b1) vs_at = cyc;
    end
    chk("restart_first_hsync", hs_at, 32'd11);
    chk("restart_first_vsync", vs_at, 32'd76);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
